// File: rtl/vc_input_unit.sv
// Router input unit: one FIFO per virtual channel with wormhole route latching,
// on/off backpressure and sticky error flags. Define VC_INPUT_CREDIT_FC_EN for credit flow control.
package vc_input_unit_pkg;
  typedef enum logic [1:0] {
    FLIT_HEADER = 2'd0,
    FLIT_BODY   = 2'd1,
    FLIT_TAIL   = 2'd2,
    FLIT_HT     = 2'd3
  } flit_type_t;

  typedef struct packed {
    flit_type_t  flit_type;
    logic [2:0]  vc_id;
    logic [2:0]  next_hop_port;
  } header_t;

  typedef struct packed {
    header_t     header;
    logic [23:0] payload;
  } flit_t;
endpackage

module vc_input_unit
  import vc_input_unit_pkg::*;
#(
  parameter int VC_NUM        = 2,
  parameter int FIFO_DEPTH    = 4,
  parameter int OFF_THRESHOLD = 1,
  parameter int PORT_NUM      = 5
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             wr_en_in,
  input  flit_t                            flit_in,
  input  logic [VC_NUM-1:0]                sa_grant,
  output flit_t [VC_NUM-1:0]               ip_flit_out,
  output logic  [VC_NUM-1:0]               ip_empty,
  output logic  [VC_NUM-1:0][PORT_NUM-1:0] ip_dest_port,
  output logic  [VC_NUM-1:0]               on_off_out,
  output logic                             err_overflow,
  output logic                             err_protocol
`ifdef VC_INPUT_CREDIT_FC_EN
  ,
  output logic  [VC_NUM-1:0]               credit_out
`endif
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_LEVEL = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] STOP_LEVEL = CW'(FIFO_DEPTH - OFF_THRESHOLD);
  localparam logic [3:0]    VC_LIMIT   = 4'(VC_NUM);

  typedef enum logic {ST_IDLE, ST_ACTIVE} pkt_state_t;

  logic [VC_NUM-1:0] w_wr_reject;
  logic [VC_NUM-1:0] w_auto_pop;
  logic              w_bad_vc;
  logic              r_err_overflow;
  logic              r_err_protocol;

  assign w_bad_vc = wr_en_in && ({1'b0, flit_in.header.vc_id} >= VC_LIMIT);

  genvar gi;
  generate
    for (gi = 0; gi < VC_NUM; gi++) begin : g_vc
      flit_t               r_mem [FIFO_DEPTH];
      logic [PW-1:0]       r_wr_ptr;
      logic [PW-1:0]       r_rd_ptr;
      logic [CW-1:0]       r_count;
      logic [CW-1:0]       w_count_next;
      pkt_state_t          r_state;
      pkt_state_t          w_state_next;
      logic [PORT_NUM-1:0] r_route;
      logic [PORT_NUM-1:0] w_route_next;
      logic [PORT_NUM-1:0] w_hop_onehot;
      logic [PORT_NUM-1:0] w_dest;
      flit_t               w_head;
      logic                w_empty;
      logic                w_full;
      logic                w_wr_req;
      logic                w_wr;
      logic                w_pop;

      assign w_head       = r_mem[r_rd_ptr];
      assign w_empty      = (r_count == '0);
      assign w_full       = (r_count == FULL_LEVEL);
      assign w_wr_req     = wr_en_in && (flit_in.header.vc_id == 3'(gi));
      assign w_wr         = w_wr_req && !w_full;
      assign w_wr_reject[gi] = w_wr_req && w_full;
      assign w_hop_onehot = PORT_NUM'(1) << w_head.header.next_hop_port;
      // Body/tail with no open packet cannot be routed, so it is flushed.
      assign w_auto_pop[gi] = !w_empty && (r_state == ST_IDLE) &&
                              ((w_head.header.flit_type == FLIT_BODY) ||
                               (w_head.header.flit_type == FLIT_TAIL));
      assign w_pop        = !w_empty && (sa_grant[gi] || w_auto_pop[gi]);
      assign w_count_next = r_count + CW'(w_wr) - CW'(w_pop);

      always_comb begin
        w_state_next = r_state;
        w_route_next = r_route;
        w_dest       = '0;
        if (!w_empty) begin
          if (r_state == ST_ACTIVE) begin
            w_dest = r_route;
            if (w_pop && ((w_head.header.flit_type == FLIT_TAIL) ||
                          (w_head.header.flit_type == FLIT_HT)))
              w_state_next = ST_IDLE;
          end else if ((w_head.header.flit_type == FLIT_HEADER) ||
                       (w_head.header.flit_type == FLIT_HT)) begin
            w_dest = w_hop_onehot;
            if (w_pop && (w_head.header.flit_type == FLIT_HEADER)) begin
              w_state_next = ST_ACTIVE;
              w_route_next = w_hop_onehot;
            end
          end
        end
      end

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          r_wr_ptr <= '0;
          r_rd_ptr <= '0;
          r_count  <= '0;
          r_state  <= ST_IDLE;
          r_route  <= '0;
        end else begin
          if (w_wr)  r_wr_ptr <= r_wr_ptr + PW'(1);
          if (w_pop) r_rd_ptr <= r_rd_ptr + PW'(1);
          r_count <= w_count_next;
          r_state <= w_state_next;
          r_route <= w_route_next;
        end
      end

      always_ff @(posedge clk) begin
        if (!reset && w_wr) r_mem[r_wr_ptr] <= flit_in;
      end

`ifdef VC_INPUT_CREDIT_FC_EN
      logic r_credit;
      always_ff @(posedge clk or posedge reset) begin
        if (reset) r_credit <= 1'b0;
        else       r_credit <= w_pop;
      end
      assign credit_out[gi] = r_credit;
      assign on_off_out[gi] = 1'b0;
`else
      logic r_on_off;
      always_ff @(posedge clk or posedge reset) begin
        if (reset) r_on_off <= 1'b0;
        else       r_on_off <= (w_count_next >= STOP_LEVEL);
      end
      assign on_off_out[gi] = r_on_off;
`endif

      assign ip_flit_out[gi]  = w_head;
      assign ip_empty[gi]     = w_empty;
      assign ip_dest_port[gi] = w_dest;
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_err_overflow <= 1'b0;
      r_err_protocol <= 1'b0;
    end else begin
      r_err_overflow <= r_err_overflow | w_bad_vc | (|w_wr_reject);
      r_err_protocol <= r_err_protocol | (|w_auto_pop);
    end
  end

  assign err_overflow = r_err_overflow;
  assign err_protocol = r_err_protocol;

endmodule

// File: tb/tb_vc_input_unit.sv
// Directed, table-driven bench for vc_input_unit (2 VCs, depth 4, threshold 1, 5 ports).
// Build with VC_INPUT_CREDIT_FC_EN to exercise the credit variant as well.
module tb_vc_input_unit;
  import vc_input_unit_pkg::*;

`ifdef VC_INPUT_CREDIT_FC_EN
  localparam bit CREDIT = 1'b1;
`else
  localparam bit CREDIT = 1'b0;
`endif

  typedef struct {
    logic       wr;
    flit_type_t ft;
    logic [2:0] vc;
    logic [2:0] hop;
    logic [7:0] pay;
    logic [1:0] gnt;
    logic [1:0] e_empty;
    logic [4:0] e_d0;
    logic [4:0] e_d1;
    logic [1:0] e_oo;
    logic       e_ovf;
    logic       e_prot;
    logic [7:0] e_h0;
    logic [7:0] e_h1;
  } vec_t;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             wr_en_in = 1'b0;
  flit_t            flit_in = '0;
  logic [1:0]       sa_grant = '0;
  flit_t [1:0]      ip_flit_out;
  logic [1:0]       ip_empty;
  logic [1:0][4:0]  ip_dest_port;
  logic [1:0]       on_off_out;
  logic             err_overflow;
  logic             err_protocol;
`ifdef VC_INPUT_CREDIT_FC_EN
  logic [1:0]       credit_out;
`endif

  int checks = 0;
  int errors = 0;
  vec_t vecs[$];

  vc_input_unit #(
    .VC_NUM(2), .FIFO_DEPTH(4), .OFF_THRESHOLD(1), .PORT_NUM(5)
  ) dut (
    .clk(clk), .reset(reset), .wr_en_in(wr_en_in), .flit_in(flit_in),
    .sa_grant(sa_grant), .ip_flit_out(ip_flit_out), .ip_empty(ip_empty),
    .ip_dest_port(ip_dest_port), .on_off_out(on_off_out),
    .err_overflow(err_overflow), .err_protocol(err_protocol)
`ifdef VC_INPUT_CREDIT_FC_EN
    , .credit_out(credit_out)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic wr, input flit_type_t ft, input logic [2:0] vc,
                              input logic [2:0] hop, input logic [7:0] pay,
                              input logic [1:0] gnt, input logic [1:0] e_empty,
                              input logic [4:0] e_d0, input logic [4:0] e_d1,
                              input logic [1:0] e_oo, input logic e_ovf,
                              input logic e_prot, input logic [7:0] e_h0,
                              input logic [7:0] e_h1);
    vec_t v;
    v.wr = wr; v.ft = ft; v.vc = vc; v.hop = hop; v.pay = pay; v.gnt = gnt;
    v.e_empty = e_empty; v.e_d0 = e_d0; v.e_d1 = e_d1; v.e_oo = e_oo;
    v.e_ovf = e_ovf; v.e_prot = e_prot; v.e_h0 = e_h0; v.e_h1 = e_h1;
    return v;
  endfunction

  task automatic apply(input vec_t v, input int idx);
    logic [1:0] exp_oo;
    wr_en_in = v.wr;
    flit_in = '0;
    flit_in.header.flit_type = v.ft;
    flit_in.header.vc_id = v.vc;
    flit_in.header.next_hop_port = v.hop;
    flit_in.payload = {16'h0, v.pay};
    sa_grant = v.gnt;
    @(posedge clk);
    #1;
    wr_en_in = 1'b0;
    sa_grant = '0;
    exp_oo = CREDIT ? 2'b00 : v.e_oo;
    $display("step %0d: wr=%0b vc=%0d pay=%0h gnt=%b -> empty=%b d0=%b d1=%b onoff=%b ovf=%b prot=%b",
             idx, v.wr, v.vc, v.pay, v.gnt, ip_empty, ip_dest_port[0], ip_dest_port[1],
             on_off_out, err_overflow, err_protocol);
    chk("ip_empty", idx, 32'(ip_empty), 32'(v.e_empty));
    chk("dest0", idx, 32'(ip_dest_port[0]), 32'(v.e_d0));
    chk("dest1", idx, 32'(ip_dest_port[1]), 32'(v.e_d1));
    chk("on_off", idx, 32'(on_off_out), 32'(exp_oo));
    chk("err_overflow", idx, 32'(err_overflow), 32'(v.e_ovf));
    chk("err_protocol", idx, 32'(err_protocol), 32'(v.e_prot));
    if (!v.e_empty[0]) chk("head0", idx, 32'(ip_flit_out[0].payload[7:0]), 32'(v.e_h0));
    if (!v.e_empty[1]) chk("head1", idx, 32'(ip_flit_out[1].payload[7:0]), 32'(v.e_h1));
  endtask

  initial begin
    // Packet on VC1 granted every cycle, then a grant to an empty VC.
    vecs.push_back(mk(1, FLIT_HEADER, 1, 2, 8'h11, 2'b00, 2'b01, 5'b0, 5'b00100, 2'b00, 0, 0, 8'h0, 8'h11));
    vecs.push_back(mk(1, FLIT_BODY,   1, 0, 8'h12, 2'b10, 2'b01, 5'b0, 5'b00100, 2'b00, 0, 0, 8'h0, 8'h12));
    vecs.push_back(mk(1, FLIT_TAIL,   1, 0, 8'h13, 2'b10, 2'b01, 5'b0, 5'b00100, 2'b00, 0, 0, 8'h0, 8'h13));
    vecs.push_back(mk(0, FLIT_HEADER, 0, 0, 8'h00, 2'b10, 2'b11, 5'b0, 5'b0,     2'b00, 0, 0, 8'h0, 8'h0));
    vecs.push_back(mk(0, FLIT_HEADER, 0, 0, 8'h00, 2'b10, 2'b11, 5'b0, 5'b0,     2'b00, 0, 0, 8'h0, 8'h0));
    // Fill VC0 to full, overflow, then drain to two flits.
    vecs.push_back(mk(1, FLIT_HEADER, 0, 1, 8'h21, 2'b00, 2'b10, 5'b00010, 5'b0, 2'b00, 0, 0, 8'h21, 8'h0));
    vecs.push_back(mk(1, FLIT_HEADER, 0, 1, 8'h22, 2'b00, 2'b10, 5'b00010, 5'b0, 2'b00, 0, 0, 8'h21, 8'h0));
    vecs.push_back(mk(1, FLIT_HEADER, 0, 1, 8'h23, 2'b00, 2'b10, 5'b00010, 5'b0, 2'b01, 0, 0, 8'h21, 8'h0));
    vecs.push_back(mk(1, FLIT_HEADER, 0, 1, 8'h24, 2'b00, 2'b10, 5'b00010, 5'b0, 2'b01, 0, 0, 8'h21, 8'h0));
    vecs.push_back(mk(1, FLIT_HEADER, 0, 1, 8'h25, 2'b00, 2'b10, 5'b00010, 5'b0, 2'b01, 1, 0, 8'h21, 8'h0));
    vecs.push_back(mk(0, FLIT_HEADER, 0, 0, 8'h00, 2'b01, 2'b10, 5'b00010, 5'b0, 2'b01, 1, 0, 8'h22, 8'h0));
    vecs.push_back(mk(0, FLIT_HEADER, 0, 0, 8'h00, 2'b01, 2'b10, 5'b00010, 5'b0, 2'b00, 1, 0, 8'h23, 8'h0));
    // Simultaneous write and pop for ten cycles across pointer wrap.
    for (int k = 1; k <= 10; k++) begin
      logic [7:0] head;
      head = (k == 1) ? 8'h24 : 8'(8'h30 + k - 2);
      vecs.push_back(mk(1, FLIT_BODY, 0, 0, 8'(8'h30 + k - 1), 2'b01, 2'b10, 5'b00010, 5'b0,
                        2'b00, 1, 0, head, 8'h0));
    end
    vecs.push_back(mk(1, FLIT_TAIL,   0, 0, 8'h3A, 2'b01, 2'b10, 5'b00010, 5'b0, 2'b00, 1, 0, 8'h39, 8'h0));
    vecs.push_back(mk(0, FLIT_HEADER, 0, 0, 8'h00, 2'b01, 2'b10, 5'b00010, 5'b0, 2'b00, 1, 0, 8'h3A, 8'h0));
    vecs.push_back(mk(0, FLIT_HEADER, 0, 0, 8'h00, 2'b01, 2'b11, 5'b0,     5'b0, 2'b00, 1, 0, 8'h0,  8'h0));
    // Stray body at IDLE is flushed; the next header routes normally.
    vecs.push_back(mk(1, FLIT_BODY,   0, 0, 8'h41, 2'b00, 2'b10, 5'b0,     5'b0, 2'b00, 1, 0, 8'h41, 8'h0));
    vecs.push_back(mk(1, FLIT_HEADER, 0, 3, 8'h42, 2'b00, 2'b10, 5'b01000, 5'b0, 2'b00, 1, 1, 8'h42, 8'h0));
    vecs.push_back(mk(0, FLIT_HEADER, 0, 0, 8'h00, 2'b01, 2'b11, 5'b0,     5'b0, 2'b00, 1, 1, 8'h0,  8'h0));
    vecs.push_back(mk(1, FLIT_BODY,   0, 0, 8'h43, 2'b00, 2'b10, 5'b01000, 5'b0, 2'b00, 1, 1, 8'h43, 8'h0));

    // Reset with inputs active: everything must stay cleared.
    wr_en_in = 1'b1;
    flit_in.header.flit_type = FLIT_HEADER;
    sa_grant = 2'b11;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_empty", -1, 32'(ip_empty), 32'h3);
    chk("rst_dest", -1, 32'(ip_dest_port), 32'h0);
    chk("rst_onoff", -1, 32'(on_off_out), 32'h0);
    chk("rst_errs", -1, 32'({err_overflow, err_protocol}), 32'h0);
`ifdef VC_INPUT_CREDIT_FC_EN
    chk("rst_credit", -1, 32'(credit_out), 32'h0);
`endif
    reset = 1'b0;
    wr_en_in = 1'b0;
    sa_grant = '0;

    foreach (vecs[i]) apply(vecs[i], i);

    // Reset mid-packet (VC0 is ACTIVE with a body held).
    reset = 1'b1;
    #2;
    chk("mid_rst_empty", 100, 32'(ip_empty), 32'h3);
    chk("mid_rst_dest", 100, 32'(ip_dest_port), 32'h0);
    chk("mid_rst_onoff", 100, 32'(on_off_out), 32'h0);
    chk("mid_rst_errs", 100, 32'({err_overflow, err_protocol}), 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    apply(mk(1, FLIT_HT,     0, 4, 8'h44, 2'b00, 2'b10, 5'b10000, 5'b0, 2'b00, 0, 0, 8'h44, 8'h0), 101);
    apply(mk(0, FLIT_HEADER, 0, 0, 8'h00, 2'b01, 2'b11, 5'b0,     5'b0, 2'b00, 0, 0, 8'h0,  8'h0), 102);
    apply(mk(1, FLIT_HEADER, 2, 0, 8'h50, 2'b00, 2'b11, 5'b0,     5'b0, 2'b00, 1, 0, 8'h0,  8'h0), 103);

`ifdef VC_INPUT_CREDIT_FC_EN
    apply(mk(1, FLIT_HT, 1, 0, 8'h61, 2'b00, 2'b01, 5'b0, 5'b00001, 2'b00, 1, 0, 8'h0, 8'h61), 104);
    apply(mk(1, FLIT_HT, 1, 0, 8'h62, 2'b00, 2'b01, 5'b0, 5'b00001, 2'b00, 1, 0, 8'h0, 8'h61), 105);
    apply(mk(1, FLIT_HT, 1, 0, 8'h63, 2'b00, 2'b01, 5'b0, 5'b00001, 2'b00, 1, 0, 8'h0, 8'h61), 106);
    for (int p = 0; p < 3; p++) begin
      sa_grant = 2'b10;
      @(posedge clk);
      #1;
      sa_grant = '0;
      $display("credit pop %0d: credit=%b onoff=%b", p, credit_out, on_off_out);
      chk("credit_pulse", 110 + p, 32'(credit_out), 32'h2);
      chk("credit_onoff", 110 + p, 32'(on_off_out), 32'h0);
      @(posedge clk);
      #1;
      $display("credit idle %0d: credit=%b", p, credit_out);
      chk("credit_low", 110 + p, 32'(credit_out), 32'h0);
    end
    chk("credit_drained", 113, 32'(ip_empty), 32'h3);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vc_input_unit.md
VC_INPUT_UNIT -- requirements
Module: vc_input_unit

Interface
REQ-001 SHALL have parameter VC_NUM, default 2: number of virtual channels (1..8).
REQ-002 SHALL have parameter FIFO_DEPTH, default 4: flits per VC, a power of two, at least 2.
REQ-003 SHALL have parameter OFF_THRESHOLD, default 1: free slots remaining at which stop is raised (0..FIFO_DEPTH-1).
REQ-004 SHALL have parameter PORT_NUM, default 5: output port count for the dest one-hot.
REQ-005 SHALL have port clk, input, 1: single clock; all state on rising edge.
REQ-006 SHALL have port reset, input, 1: asynchronous, active-high.
REQ-007 SHALL have port wr_en_in, input, 1: flit_in valid this cycle.
REQ-008 SHALL have port flit_in, input, flit_t: incoming flit; header.vc_id selects the VC.
REQ-009 SHALL have port sa_grant, input, VC_NUM: one-hot pop request, at most one bit set.
REQ-010 SHALL have port ip_flit_out, output, VC_NUM x flit_t: head flit per VC.
REQ-011 SHALL have port ip_empty, output, VC_NUM: VC FIFO empty.
REQ-012 SHALL have port ip_dest_port, output, VC_NUM x PORT_NUM: one-hot route request per VC, zero when none.
REQ-013 SHALL have port on_off_out, output, VC_NUM: 1 = upstream stop sending on that VC.
REQ-014 SHALL have port err_overflow, output, 1: sticky write-to-full flag.
REQ-015 SHALL have port err_protocol, output, 1: sticky non-header-at-IDLE flag.
REQ-016 SHALL have port credit_out, output, VC_NUM: present only when the credit macro is defined.

Function
REQ-017 SHALL write flit_in into FIFO[vc_id] on a rising edge with wr_en_in=1; the flit is at the head, ip_empty low, from the next cycle.
REQ-018 SHALL drop a write to a full VC, leave its contents unchanged, and set err_overflow.
REQ-019 SHALL drop a write with vc_id >= VC_NUM and set err_overflow.
REQ-020 SHALL pop the head of VC v on the edge where sa_grant[v]=1 and the VC is non-empty; a grant to an empty VC is ignored.
REQ-021 SHALL, on simultaneous write and pop of the same non-empty VC, keep occupancy unchanged; the empty-VC case is a write only, with no bypass.
REQ-022 SHALL wrap per-VC pointers modulo FIFO_DEPTH and hold occupancy in log2(FIFO_DEPTH)+1 bits.
REQ-023 SHALL keep per-VC packet state IDLE or ACTIVE, plus a latched PORT_NUM-bit route register.
REQ-024 SHALL, in IDLE with HEADER or HT at the head, drive ip_dest_port as the one-hot decode of header.next_hop_port.
REQ-025 SHALL go IDLE->ACTIVE and latch the route when a HEADER pops; an HT pop stays IDLE.
REQ-026 SHALL, in ACTIVE, drive the latched route on ip_dest_port for every non-empty head, go ACTIVE->IDLE on TAIL pop, and send body flits to the same port.
REQ-027 SHALL, in IDLE with BODY or TAIL at the head, drive ip_dest_port to 0, auto-pop that flit on the next edge, and set err_protocol.
REQ-028 SHALL drive ip_dest_port[v] to 0 whenever VC v is empty.
REQ-029 SHALL register on_off_out[v] = (occupancy_next >= FIFO_DEPTH - OFF_THRESHOLD), so it is valid in the cycle after the triggering edge.
REQ-030 SHALL keep the ip_flit_out contents of an empty VC as don't-care; the bench checks them only when ip_empty=0.

Reset
REQ-031 SHALL, on reset asserted at any time including mid-packet, immediately empty all FIFOs, zero the pointers and counts, set every VC to IDLE and clear the route registers.
REQ-032 SHALL, while in reset, hold ip_empty all-ones, ip_dest_port 0, on_off_out 0, err flags 0 and credit_out 0.
REQ-033 SHALL ignore wr_en_in and sa_grant while reset is high; normal operation begins on the first edge after deassertion.

Configuration
REQ-034 SHALL, with VC_INPUT_CREDIT_FC_EN defined, pulse credit_out[v] high for one cycle, in the cycle after each pop of VC v, including auto-pops, and tie on_off_out to 0.
REQ-035 SHALL, without VC_INPUT_CREDIT_FC_EN, omit credit_out and use on_off_out per REQ-029.

Verification (VC_NUM=2, FIFO_DEPTH=4, OFF_THRESHOLD=1, PORT_NUM=5)
REQ-036 SHALL cover: HEADER(next_hop=2), BODY, TAIL written to VC1 and then granted each cycle -> ip_dest_port[1]=5'b00100 for all three flits, back to IDLE after TAIL, ip_empty[1]=1.
REQ-037 SHALL cover: 3 writes to VC0 with no grants -> on_off_out[0]=1 the cycle after the 3rd; a 5th write while full -> dropped and err_overflow=1.
REQ-038 SHALL cover: write plus grant on VC0 with 2 flits held, every cycle for 10 cycles -> occupancy stays 2, FIFO order preserved through pointer wrap.
REQ-039 SHALL cover: BODY written to an idle VC0 -> ip_dest_port[0]=0, flit auto-popped, err_protocol=1; a following HEADER routes normally.
REQ-040 SHALL cover: reset asserted between HEADER pop and TAIL -> all ip_empty=1, state IDLE; a new HT(next_hop=4) after release -> 5'b10000.
REQ-041 SHALL cover, with VC_INPUT_CREDIT_FC_EN: 3 pops on VC1 -> 3 single-cycle credit_out[1] pulses, each one cycle after its pop, and on_off_out=0 throughout.
